// File: rtl/gate_bus_rr_sched.sv
// Round-robin scheduler that shares one registered gate datapath among C_NUM_REQ requesters.
// One operation is in flight at a time; the result returns to its owner with a one-hot pulse.
module gate_bus_rr_sched #(
  parameter int C_NUM_REQ    = 4,
  parameter int C_WIDTH      = 16,
  parameter int C_DP_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           SCLR,
  input  logic [C_NUM_REQ-1:0]           REQ,
  input  logic [C_NUM_REQ*C_WIDTH-1:0]   REQ_DATA,
  input  logic [C_NUM_REQ-1:0]           REQ_CTRL,
  output logic [C_NUM_REQ-1:0]           GNT,
  output logic [C_NUM_REQ-1:0]           RSP_VALID,
  output logic [C_WIDTH-1:0]             RSP_DATA,
  output logic [C_WIDTH-1:0]             DP_I,
  output logic                           DP_CTRL,
  output logic                           DP_CE,
  input  logic [C_WIDTH-1:0]             DP_Q,
  output logic                           BUSY
);

  localparam int IDX_W = $clog2(C_NUM_REQ);
  localparam logic [C_NUM_REQ-1:0] ONE_HOT_0 = C_NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [C_NUM_REQ-1:0] gnt_q, gnt_d;
  logic [C_NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [C_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [C_WIDTH-1:0]   dp_i_q, dp_i_d;
  logic                 dp_ctrl_q, dp_ctrl_d;
  logic                 dp_ce_q, dp_ce_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       scan_sum;
  logic [IDX_W-1:0]     scan_idx;
  logic [C_WIDTH-1:0]   win_data;
  logic                 win_ctrl;

  // First requester at or above the pointer, wrapping back to index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (scan_sum >= (IDX_W+1)'(C_NUM_REQ)) begin
        scan_sum = scan_sum - (IDX_W+1)'(C_NUM_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_ctrl = 1'b0;
    for (int j = 0; j < C_NUM_REQ; j++) begin
      if (win_idx == IDX_W'(j)) begin
        win_data = REQ_DATA[j*C_WIDTH +: C_WIDTH];
        win_ctrl = REQ_CTRL[j];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    dp_i_d      = dp_i_q;
    dp_ctrl_d   = dp_ctrl_q;
    dp_ce_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          owner_d   = win_idx;
          dp_i_d    = win_data;
          dp_ctrl_d = win_ctrl;
          gnt_d     = ONE_HOT_0 << win_idx;
          dp_ce_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ptr_d   = (owner_q == IDX_W'(C_NUM_REQ-1)) ? '0 : owner_q + IDX_W'(1);
        cnt_d   = 4'(C_DP_LATENCY - 1);
        state_d = (C_DP_LATENCY == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_data_d  = DP_Q;
        rsp_valid_d = ONE_HOT_0 << owner_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      dp_i_q      <= '0;
      dp_ctrl_q   <= 1'b0;
      dp_ce_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      dp_i_q      <= dp_i_d;
      dp_ctrl_q   <= dp_ctrl_d;
      dp_ce_q     <= dp_ce_d;
      busy_q      <= busy_d;
    end
  end

  assign GNT       = gnt_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign DP_I      = dp_i_q;
  assign DP_CTRL   = dp_ctrl_q;
  assign DP_CE     = dp_ce_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/gate_bus_rr_sched.md
Name:
gate_bus_rr_sched

Overview:
- Round-robin scheduler that shares one registered gate-bit-bus datapath (bus-wide gate of I against CTRL, registered output Q) among C_NUM_REQ requesters.
- Arbitrates requests, captures the winner's operand and control bit, and issues one datapath operation.
- Waits the datapath's fixed latency, captures the result, and returns it to the owning requester with a one-hot valid pulse.
- Sits between requester logic and the shared gate datapath instance.

Parameters:
- C_NUM_REQ, 4, number of requesters; legal range 2..8.
- C_WIDTH, 16, datapath operand/result width.
- C_DP_LATENCY, 1, cycles from datapath CE-asserted issue cycle to valid Q; legal range 1..15.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- SCLR  in  1  synchronous, active-high reset.
- REQ  in  C_NUM_REQ  per-requester request level.
- REQ_DATA  in  C_NUM_REQ*C_WIDTH  operands; requester k occupies bits [k*C_WIDTH +: C_WIDTH].
- REQ_CTRL  in  C_NUM_REQ  per-requester CTRL bit.
- GNT  out  C_NUM_REQ  one-hot, one-cycle grant pulse.
- RSP_VALID  out  C_NUM_REQ  one-hot, one-cycle result-valid pulse.
- RSP_DATA  out  C_WIDTH  result; held until next capture.
- DP_I  out  C_WIDTH  operand to datapath I.
- DP_CTRL  out  1  control bit to datapath CTRL.
- DP_CE  out  1  datapath register enable; one-cycle pulse per operation.
- DP_Q  in  C_WIDTH  datapath registered result Q.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is SCLR, synchronous, active-high.
- SCLR has priority over all other activity, including mid-operation. On SCLR:
  - state goes to IDLE;
  - round-robin pointer = 0;
  - wait counter = 0;
  - the in-flight operation is discarded, with no RSP_VALID.
- Output values after SCLR: GNT=0, RSP_VALID=0, RSP_DATA=0, DP_I=0, DP_CTRL=0, DP_CE=0, BUSY=0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQ bit is set, select the winner: first set bit scanning upward from the pointer, wrapping past C_NUM_REQ-1 to 0.
  - Latch owner index, REQ_DATA slice into DP_I, and REQ_CTRL bit into DP_CTRL.
  - Set GNT[owner] and DP_CE for the next cycle, then go to ISSUE.
  - If no REQ bit is set, stay in IDLE.
- ISSUE (1 cycle):
  - GNT[owner]=1 and DP_CE=1 are visible.
  - Pointer = owner+1, wrapping mod C_NUM_REQ.
  - Counter loads C_DP_LATENCY-1.
  - If C_DP_LATENCY=1, go to RESP; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when counter==1 is observed. DP_CE=0.
- RESP (1 cycle):
  - RSP_DATA <= DP_Q and RSP_VALID[owner] set for the next cycle.
  - Go to IDLE; the RSP_VALID pulse coincides with the IDLE cycle.
- DP_I and DP_CTRL hold their latched values from ISSUE through RESP. They change only on a new grant.
- Latency from REQ sampled in IDLE (cycle t):
  - GNT at t+1;
  - DP_Q sampled at end of cycle t+1+C_DP_LATENCY;
  - RSP_VALID at t+2+C_DP_LATENCY.
- Throughput: one operation per C_DP_LATENCY+2 cycles.
- Requester handshake:
  - The requester holds REQ, REQ_DATA and REQ_CTRL stable until it sees GNT.
  - It must drop REQ in the cycle after GNT unless it wants another operation.
  - Data is sampled in the arbitration cycle, so post-grant changes have no effect.
- REQ changes outside IDLE are ignored; no arbitration occurs while BUSY=1.
- Multiple simultaneous requests: exactly one is granted; the others wait for later IDLE cycles in rotated priority.
- The pointer advances only on grant; idle cycles do not rotate it.
- Back-to-back: a REQ held in the IDLE cycle that carries RSP_VALID is arbitrated in that same cycle.

Test Plan:
- Reset defaults: assert SCLR 3 cycles with REQ=4'b1111 → all outputs 0, BUSY=0, no GNT during or on the cycle after release.
- Single request (bench models DP as AND, C_DP_LATENCY=1): REQ=4'b0100, REQ_DATA slice2=16'hF0F0, REQ_CTRL[2]=1 at cycle t → GNT=4'b0100 and DP_CE=1 at t+1, DP_I=16'hF0F0 → RSP_VALID=4'b0100 at t+3 with RSP_DATA=16'hF0F0; with CTRL=0 → RSP_DATA=16'h0000.
- Round-robin fairness: hold REQ=4'b1111 continuously → grant order 0,1,2,3,0 on successive grants, each grant separated by 3 cycles.
- Rotation with gaps: pointer at 2 after granting 1; REQ=4'b0011 → grant 0; then REQ=4'b0011 again → grant 1.
- Latency parameter: C_DP_LATENCY=4, single request at t → GNT t+1, RSP_VALID t+6, BUSY high t+1..t+5.
- Reset mid-operation: SCLR in WAIT → state IDLE next cycle, no RSP_VALID ever for that operation, pointer 0; a following REQ=4'b1000 is granted normally.
